// File: rtl/d_trig_checker.sv
`default_nettype none
// ============================================================================
// Module   : d_trig_checker
// Purpose  : Monitors an external D flip-flop (D, C, Q, Qn pins) and compares
//            its Q/Qn response with an internal edge-triggered reference.
//            All observed pins are asynchronous to clk and are resynchronised
//            before use. Reports edge counts, mismatch counts and error flags.
// Ports    : clk, rst            system clock, async active-high reset
//            en_i                monitor enable (low -> IDLE, counters hold)
//            clr_i               sync clear of counters and sticky flag
//            dut_d_i/c_i/q_i/qn_i observed flip-flop pins
//            exp_q_o             reference model's expected Q
//            edge_cnt_o          saturating count of C rising edges
//            err_cnt_o           saturating count of mismatch events
//            err_o               one-cycle pulse per mismatch event
//            err_sticky_o        set on any mismatch until rst/clr
//            busy_o              high while waiting for Q/Qn to settle
// Revision : 1.0 - initial release
// ============================================================================
module d_trig_checker #(
    parameter int SETTLE = 4,   // clk cycles between edge and compare (1..15)
    parameter int CNT_W  = 8    // counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             dut_d_i,
    input  logic             dut_c_i,
    input  logic             dut_q_i,
    input  logic             dut_qn_i,
    output logic             exp_q_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_o,
    output logic             err_sticky_o,
    output logic             busy_o
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for {D, C, Q, Qn}, plus one extra C stage.
    // Q/Qn share the same latency as C so the rise cycle sees Q/Qn and C
    // change together.
    // ------------------------------------------------------------------
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic       c_p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            c_p_q   <= 1'b0;
        end else begin
            sync1_q <= {dut_d_i, dut_c_i, dut_q_i, dut_qn_i};
            sync2_q <= sync1_q;
            c_p_q   <= sync2_q[2];
        end
    end

    logic d_s, c_s, q_s, qn_s;
    assign d_s  = sync2_q[3];
    assign c_s  = sync2_q[2];
    assign q_s  = sync2_q[1];
    assign qn_s = sync2_q[0];

    // ------------------------------------------------------------------
    // State, reference model and counters
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [3:0]         settle_q, settle_d;
    logic               exp_q_q;
    logic [CNT_W-1:0]   edge_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic               err_q;
    logic               sticky_q;
    logic               busy_q;
    logic               hold_flag_q;   // one error already reported this period

    logic rise;
    logic mismatch;
    logic take_edge;
    logic err_event;

    assign rise     = c_s & ~c_p_q;
    assign mismatch = (q_s != exp_q_q) | (qn_s != ~exp_q_q);

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        take_edge = 1'b0;
        err_event = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FIRST;
                end
                ST_FIRST: begin
                    if (rise) begin
                        take_edge = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (rise) begin
                        // abandoned edge: restart, no check for it
                        take_edge = 1'b1;
                    end else if (settle_q == 4'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    err_event = mismatch;
                    if (rise) begin
                        take_edge = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // On the rise cycle Q may already reflect the new edge,
                    // so the compare is skipped there.
                    if (rise) begin
                        take_edge = 1'b1;
                    end else begin
                        err_event = mismatch & ~hold_flag_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (take_edge) begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= 4'd0;
            exp_q_q     <= 1'b0;
            edge_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            busy_q      <= 1'b0;
            hold_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            busy_q   <= (state_d == ST_SETTLE);
            err_q    <= err_event;
            // A CHECK mismatch also arms the flag so a persistent fault is
            // reported once per edge, not again in the following HOLD.
            hold_flag_q <= (state_d == ST_HOLD) ? (hold_flag_q | err_event) : 1'b0;
            if (take_edge) begin
                exp_q_q <= d_s;
            end
            if (clr_i) begin
                edge_cnt_q <= '0;
                err_cnt_q  <= '0;
                sticky_q   <= 1'b0;
            end else begin
                if (take_edge && (edge_cnt_q != CNT_MAX)) begin
                    edge_cnt_q <= edge_cnt_q + CNT_ONE;
                end
                if (err_event) begin
                    sticky_q <= 1'b1;
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_q <= err_cnt_q + CNT_ONE;
                    end
                end
            end
        end
    end

    assign exp_q_o      = exp_q_q;
    assign edge_cnt_o   = edge_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: doc/d_trig_checker.md
# d_trig_checker

Synchronous hardware monitor that observes a D flip-flop under test (its D, C, Q and Qn pins) and checks the Q/Qn response against an internal edge-triggered reference model. It is the checking end of the flip-flop stimulus interface, so lab boards can self-check the D trigger without a simulator. It runs on a fast system clock that is asynchronous to the observed C, and reports edge counts, mismatch counts and error flags.

## Interface

- SETTLE, 4: clk cycles to wait after a detected C rising edge before Q/Qn are compared (1..15).
- CNT_W, 8: width of edge and error counters.

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  monitor enable; low forces IDLE, counters hold.
- clr  in  1  synchronous clear of counters and err_sticky; higher priority than counting.
- dut_d  in  1  observed D (asynchronous to clk).
- dut_c  in  1  observed C (asynchronous to clk).
- dut_q  in  1  observed Q (asynchronous to clk).
- dut_qn  in  1  observed Qn (asynchronous to clk).
- exp_q  out  1  model's expected Q.
- edge_cnt  out  CNT_W  count of C rising edges seen while enabled; saturating.
- err_cnt  out  CNT_W  count of mismatch events; saturating.
- err  out  1  one-cycle pulse per mismatch event.
- err_sticky  out  1  set on any mismatch; cleared only by rst or clr.
- busy  out  1  high in SETTLE.

## Operation

- All four DUT inputs pass through 2-flop synchronizers (d_s, c_s, q_s, qn_s). c_s has one further register c_p for edge detection. rise = c_s & ~c_p.
- Falling C edges are ignored.
- States:
  - IDLE: entered while en=0. No counting, no checks.
  - FIRST: waits for the first rise. Q is unknown before it, so there are no checks.
  - SETTLE: a count runs from SETTLE-1 down to 0.
  - CHECK: one cycle; performs the compare.
  - HOLD: checks Q/Qn continuously until the next rise.
- Transitions:
  - IDLE→FIRST when en=1.
  - FIRST, SETTLE or HOLD → SETTLE on rise. Each such rise loads exp_q<=d_s and increments edge_cnt.
  - SETTLE→CHECK when the count reaches 0.
  - CHECK→HOLD.
  - Any state→IDLE when en=0.
- Rise during SETTLE: the settle count restarts and exp_q reloads. No check is made for the abandoned edge.
- Rise in CHECK: the compare still happens, then the FSM goes to SETTLE instead of HOLD.
- Mismatch = (q_s != exp_q) | (qn_s != ~exp_q).
- CHECK mismatch: one error event.
- HOLD mismatch: one error event per HOLD period, counted on the first mismatching cycle only. A per-period flag suppresses repeats and is cleared on leaving HOLD. This catches output glitches and clock-less changes.
- Error event: err=1 for one cycle, err_cnt+1, err_sticky=1.
- Counters saturate at 2^CNT_W-1.
- clr and an increment in the same cycle: clr wins, so the result is 0.
- Reset values: exp_q=0, edge_cnt=0, err_cnt=0, err=0, err_sticky=0, busy=0. The FSM starts in IDLE, the synchronizers and c_p are 0, and the HOLD flag is cleared.
- Asserting rst mid-SETTLE or mid-HOLD aborts immediately with no pending error. After release the FSM returns to FIRST, so no check occurs until a new edge.

## Timing

- dut_c rising at clk edge k: c_s=1 after k+2, and rise is asserted in the cycle after that edge.
- State=SETTLE, exp_q and edge_cnt update at the next edge, E.
- CHECK occurs at E+SETTLE. err pulses in the cycle after CHECK, coincident with the err_cnt update.
- Compare latency from dut_c edge is about SETTLE+4 clk cycles. DUT propagation plus synchronization must fit inside it.
- Stimulus rules:
  - D must be stable at least 3 clk cycles around each C rising edge. Otherwise exp_q is indeterminate, and the bench must not rely on it.
  - C high and low phases must each be at least 3 clk cycles.

## Test plan

- Reset: assert rst mid-run. All outputs 0 and FSM in IDLE immediately. After release with en=1, no err until the first rise plus SETTLE.
- Golden DUT: ideal DFF. C toggles every 50 clk, D pattern 0,1,1,0,1,0,1,0 changing mid-phase, 32 rises. Required: edge_cnt=32, err_cnt=0, err_sticky=0, and exp_q tracks D at each rise.
- Stuck Q: Q tied 0 and Qn=~Q, with D=1 for 3 rises. Required: exactly one err pulse per rise (err_cnt=3). err_sticky=1 persists until clr, after which both are 0.
- Qn fault: Qn equal to Q. Every CHECK flags, and err_cnt equals the number of rises.
- Hold glitch: correct DUT, but Q inverted for 10 clk mid-HOLD. Required: exactly one err. No error at the next check if Q is correct by then.
- Edge cases:
  - Rise during SETTLE: edge_cnt=2, and only one CHECK, against the second D.
  - CNT_W=2 with 5 faulty edges: err_cnt saturates at 3.
  - clr coincident with an error: err_cnt=0.
